// File: rtl/noc_pkg.sv
// Shared NoC constants: AHB codes, packet header layout,
// receive register map and receive FSM states.
package noc_pkg;

  localparam logic [1:0] HTRANS_IDLE = 2'b00;

  localparam int DEST_MSB = 31;
  localparam int DEST_LSB = 24;
  localparam int SRC_MSB  = 23;
  localparam int SRC_LSB  = 16;
  localparam int LEN_MSB  = 15;
  localparam int LEN_LSB  = 8;
  localparam int TYPE_MSB = 7;
  localparam int TYPE_LSB = 0;

  localparam int MAX_WORDS = 8;

  localparam logic [4:0] RX_HDR     = 5'd8;
  localparam logic [4:0] RX_STATUS  = 5'd9;
  localparam logic [4:0] RX_RELEASE = 5'd10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_RECV = 2'd1,
    R_HOLD = 2'd2
  } rx_state_e;

  // Payload words from the header byte length, clamped to 1..MAX_WORDS
  function automatic logic [3:0] word_count(input logic [7:0] byte_len);
    logic [5:0] w;
    w = byte_len[7:2];
    if (w == 6'd0)
      return 4'd1;
    else if (w > 6'(MAX_WORDS))
      return 4'(MAX_WORDS);
    else
      return w[3:0];
  endfunction

endpackage

// File: rtl/noc_rx_slave.sv
// NoC receive endpoint: buffers one link packet and exposes it
// to the local processor as an AHB-Lite slave with an interrupt.
module noc_rx_slave
  import noc_pkg::*;
#(
  parameter logic [1:0] X = 2'd0,
  parameter logic [1:0] Y = 2'd0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [31:0] HADDR,
  input  logic [31:0] HWDATA,
  input  logic [2:0]  HSIZE,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic        HREADY,
  input  logic        HSEL,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  input  logic        S_Req,
  input  logic [31:0] S_Data,
  output logic        S_Ack,
  output logic        Rx_Irq
);

  logic        write_en_q, read_en_q;
  logic [4:0]  word_addr_q;
  rx_state_e   state_q, state_d;
  logic [31:0] hdr_q, hdr_d;
  logic [3:0]  len_q, len_d;
  logic [2:0]  cnt_q, cnt_d;
  logic        mis_q, mis_d;
  logic [31:0] buf_q [MAX_WORDS];
  logic        buf_we;
  logic        release_w;
  logic        addr_ph;
  logic        unused_ok;

  assign unused_ok = ^{HSIZE, HWDATA, HADDR[31:7], HADDR[1:0]};

  assign HREADYOUT = 1'b1;
  assign addr_ph   = HREADY && HSEL && (HTRANS != HTRANS_IDLE);
  assign release_w = write_en_q && (word_addr_q == RX_RELEASE);

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      write_en_q  <= 1'b0;
      read_en_q   <= 1'b0;
      word_addr_q <= 5'd0;
    end else begin
      write_en_q  <= addr_ph && HWRITE;
      read_en_q   <= addr_ph && !HWRITE;
      word_addr_q <= addr_ph ? HADDR[6:2] : 5'd0;
    end
  end

  // Gated by reset so the ack drops the instant reset asserts
  assign S_Ack  = HRESETn && (state_q == R_IDLE) && S_Req;
  assign Rx_Irq = (state_q == R_HOLD);

  always_comb begin
    state_d = state_q;
    hdr_d   = hdr_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    mis_d   = mis_q;
    buf_we  = 1'b0;
    case (state_q)
      R_IDLE: begin
        if (S_Req) begin
          hdr_d   = S_Data;
          len_d   = word_count(S_Data[LEN_MSB:LEN_LSB]);
          cnt_d   = 3'd0;
          mis_d   = S_Data[DEST_LSB+3:DEST_LSB] != {X, Y};
          state_d = R_RECV;
        end
      end
      R_RECV: begin
        buf_we = 1'b1;
        if ({1'b0, cnt_q} == len_q - 4'd1)
          state_d = R_HOLD;
        else
          cnt_d = cnt_q + 3'd1;
      end
      R_HOLD: begin
        if (release_w) begin
          mis_d   = 1'b0;
          state_d = R_IDLE;
        end
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= R_IDLE;
      hdr_q   <= 32'd0;
      len_q   <= 4'd0;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      hdr_q   <= hdr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      mis_q   <= mis_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (buf_we)
      buf_q[cnt_q] <= S_Data;
  end

  always_comb begin
    HRDATA = 32'd0;
    if (read_en_q) begin
      unique case (1'b1)
        (word_addr_q[4:3] == 2'b00):
          HRDATA = buf_q[word_addr_q[2:0]];
        (word_addr_q == RX_HDR):
          HRDATA = hdr_q;
        (word_addr_q == RX_STATUS):
          HRDATA = {20'd0, len_q, 5'd0, mis_q,
                    state_q == R_RECV,
                    state_q == R_HOLD};
        default:
          HRDATA = 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_noc_rx_slave.sv
// Directed bench for noc_rx_slave with a read-data scoreboard.
// Two instances share stimulus to cover two node locations.
module tb_noc_rx_slave;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic [31:0] HADDR;
  logic [31:0] HWDATA;
  logic [2:0]  HSIZE;
  logic [1:0]  HTRANS;
  logic        HWRITE;
  logic        HREADY;
  logic        HSEL;
  logic [31:0] HRDATA, HRDATA2;
  logic        HREADYOUT, HREADYOUT2;
  logic        S_Req;
  logic [31:0] S_Data;
  logic        S_Ack, S_Ack2;
  logic        Rx_Irq, Rx_Irq2;

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [31:0] exp_q [$];
  string       tag_q [$];

  always #5 HCLK = ~HCLK;

  noc_rx_slave #(.X(2'd1), .Y(2'd1)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR),
    .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT),
    .S_Req(S_Req), .S_Data(S_Data), .S_Ack(S_Ack),
    .Rx_Irq(Rx_Irq)
  );

  noc_rx_slave #(.X(2'd1), .Y(2'd2)) dut2 (
    .HCLK(HCLK), .HRESETn(HRESETn), .HADDR(HADDR),
    .HWDATA(HWDATA), .HSIZE(HSIZE), .HTRANS(HTRANS),
    .HWRITE(HWRITE), .HREADY(HREADY), .HSEL(HSEL),
    .HRDATA(HRDATA2), .HREADYOUT(HREADYOUT2),
    .S_Req(S_Req), .S_Data(S_Data), .S_Ack(S_Ack2),
    .Rx_Irq(Rx_Irq2)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic ahb_rd(input logic [4:0] a, output logic [31:0] d1,
                        output logic [31:0] d2);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b0;
    HADDR = {25'd0, a, 2'b00};
    @(posedge HCLK); #1;
    d1 = HRDATA; d2 = HRDATA2;
    HSEL = 1'b0; HTRANS = 2'b00;
  endtask

  task automatic rd(input logic [4:0] a, input logic [31:0] e,
                    input string tag);
    logic [31:0] d1, d2;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    ahb_rd(a, d1, d2);
    chk(tag_q.pop_front(), d1, exp_q.pop_front());
  endtask

  task automatic rd2(input logic [4:0] a, input logic [31:0] e,
                     input string tag);
    logic [31:0] d1, d2;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    ahb_rd(a, d1, d2);
    chk(tag_q.pop_front(), d2, exp_q.pop_front());
  endtask

  task automatic ahb_wr(input logic [4:0] a);
    @(negedge HCLK);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1;
    HADDR = {25'd0, a, 2'b00};
    @(posedge HCLK); #1;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    HWDATA = $urandom;
  endtask

  task automatic release_buf(input string tag);
    ahb_wr(5'd10);
    @(posedge HCLK); #1;
    chk(tag, Rx_Irq, 1'b0);
  endtask

  task automatic feed_words(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge HCLK);
      S_Req = 1'b0;
      S_Data = base + 32'(i);
      @(posedge HCLK);
    end
  endtask

  task automatic send(input logic [31:0] hdr, input logic [31:0] base,
                      input int n, input string tag);
    @(negedge HCLK);
    S_Req = 1'b1; S_Data = hdr;
    #1 chk(tag, S_Ack, 1'b1);
    @(posedge HCLK);
    feed_words(base, n);
    #1;
  endtask

  initial begin
    HRESETn = 1'b0; HADDR = '0; HWDATA = '0; HSIZE = 3'b010;
    HTRANS = 2'b00; HWRITE = 1'b0; HREADY = 1'b1; HSEL = 1'b0;
    S_Req = 1'b0; S_Data = '0;
    repeat (2) @(posedge HCLK);
    #1;
    chk("rst_ack", S_Ack, 1'b0);
    chk("rst_irq", Rx_Irq, 1'b0);
    chk("rst_hrdata", HRDATA, 32'd0);
    chk("hreadyout", HREADYOUT, 1'b1);
    @(negedge HCLK); HRESETn = 1'b1;

    // 1: basic 4-word packet
    rd(5'd9, 32'd0, "t1_status_rst");
    rd(5'd8, 32'd0, "t1_hdr_rst");
    send(32'h05001001, 32'hA0, 4, "t1_ack");
    chk("t1_irq", Rx_Irq, 1'b1);
    rd(5'd9, 32'h0401, "t1_status");
    for (int i = 0; i < 4; i++)
      rd(5'(i), 32'hA0 + 32'(i), $sformatf("t1_buf%0d", i));
    rd(5'd8, 32'h05001001, "t1_hdr");

    // 2: request held while full, then release
    @(negedge HCLK); S_Req = 1'b1; S_Data = 32'h05000802;
    for (int i = 0; i < 10; i++) begin
      @(posedge HCLK); #1;
      chk($sformatf("t2_hold_ack%0d", i), S_Ack, 1'b0);
    end
    ahb_wr(5'd10);
    chk("t2_ack_rel_cycle", S_Ack, 1'b0);
    @(posedge HCLK); #1;
    chk("t2_irq_idle", Rx_Irq, 1'b0);
    chk("t2_ack_idle", S_Ack, 1'b1);
    @(posedge HCLK);
    feed_words(32'hB0, 2);
    rd(5'd8, 32'h05000802, "t2_hdr");
    rd(5'd9, 32'h0201, "t2_status");
    rd(5'd0, 32'hB0, "t2_buf0");
    rd(5'd1, 32'hB1, "t2_buf1");
    release_buf("t2_rel");

    // 3: length clamping
    send(32'h05000203, 32'hC0, 1, "t3a_ack");
    chk("t3a_irq", Rx_Irq, 1'b1);
    rd(5'd9, 32'h0101, "t3a_status");
    rd(5'd0, 32'hC0, "t3a_buf0");
    rd(5'd1, 32'hB1, "t3a_buf1_stale");
    release_buf("t3a_rel");
    send(32'h05004007, 32'hD0, 7, "t3b_ack");
    chk("t3b_irq_7", Rx_Irq, 1'b0);
    feed_words(32'hD7, 1);
    #1 chk("t3b_irq_8", Rx_Irq, 1'b1);
    rd(5'd9, 32'h0801, "t3b_status");
    for (int i = 0; i < 8; i++)
      rd(5'(i), 32'hD0 + 32'(i), $sformatf("t3b_buf%0d", i));
    release_buf("t3b_rel");

    // 4: destination mismatch on node (1,2)
    send(32'h09000404, 32'hE0, 1, "t4_ack");
    rd2(5'd9, 32'h0105, "t4_status_mis");
    rd(5'd9, 32'h0105, "t4_status_mis_a");
    rd2(5'd0, 32'hE0, "t4_buf0");
    release_buf("t4_rel");
    rd2(5'd9, 32'h0100, "t4_status_rel");
    send(32'h06000404, 32'hE1, 1, "t4b_ack");
    rd2(5'd9, 32'h0101, "t4b_status_match");
    rd(5'd9, 32'h0105, "t4b_status_other");
    release_buf("t4b_rel");

    // 5: reset mid-packet
    @(negedge HCLK); S_Req = 1'b1; S_Data = 32'h05002008;
    @(posedge HCLK);
    feed_words(32'hF0, 2);
    @(negedge HCLK);
    S_Req = 1'b1; S_Data = 32'hF2; HRESETn = 1'b0;
    #1;
    chk("t5_ack_rst", S_Ack, 1'b0);
    chk("t5_irq_rst", Rx_Irq, 1'b0);
    repeat (2) @(posedge HCLK);
    @(negedge HCLK); S_Req = 1'b0; HRESETn = 1'b1;
    rd(5'd9, 32'd0, "t5_status");
    rd(5'd8, 32'd0, "t5_hdr");
    send(32'h05000405, 32'h60, 1, "t5_ack");
    rd(5'd9, 32'h0101, "t5_status_pkt");
    rd(5'd0, 32'h60, "t5_buf0");
    release_buf("t5_rel");

    // 6: release outside R_HOLD
    ahb_wr(5'd10);
    @(posedge HCLK); #1;
    rd(5'd9, 32'h0100, "t6_status_idle");
    @(negedge HCLK); S_Req = 1'b1; S_Data = 32'h05000C06;
    #1 chk("t6_ack", S_Ack, 1'b1);
    @(posedge HCLK);
    @(negedge HCLK);
    S_Req = 1'b0; S_Data = 32'h70;
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = 1'b1; HADDR = 32'd40;
    @(posedge HCLK);
    @(negedge HCLK);
    S_Data = 32'h71;
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
    @(posedge HCLK);
    @(negedge HCLK);
    S_Data = 32'h72;
    @(posedge HCLK); #1;
    chk("t6_irq", Rx_Irq, 1'b1);
    rd(5'd9, 32'h0301, "t6_status");
    for (int i = 0; i < 3; i++)
      rd(5'(i), 32'h70 + 32'(i), $sformatf("t6_buf%0d", i));
    rd(5'd8, 32'h05000C06, "t6_hdr");
    release_buf("t6_rel");

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
